// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
//  Module      : button_reader
//  Description : Four-button input port. Synchronizes and debounces the raw
//                buttons, turns stable presses into colour events and queues
//                them in a small FIFO that the processor pops with a load
//                from BTN_ADDR and flushes with a store of 1 to BTN_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_reader #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          DEPTH           = 4,
    parameter logic [11:0] BTN_ADDR        = 12'd7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               btn,
    input  logic [11:0]              mem_addr,
    input  logic                     mem_ren,
    input  logic                     mem_wen,
    input  logic [31:0]              mem_wdata,
    output logic                     hit,
    output logic [31:0]              data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [3:0]               pressed
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [7:0]      c_CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      w_stable;
    logic [3:0]      r_stable_d;
    logic [3:0]      w_rise;
    logic            w_push;
    logic            w_multi;
    logic [1:0]      w_code;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_wr;
    logic            w_drop;
    logic [1:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_unused_wdata;

    // Only bit 0 of a store carries meaning (flush request).
    assign w_unused_wdata = ^mem_wdata[31:1];

    // Two-flop synchronizer on every raw button line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [7:0] r_cnt;
            logic       r_level;

            // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[gi] != r_level) begin
                    if (r_cnt == c_CNT_MAX) begin
                        r_level <= r_sync2[gi];
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_stable[gi] = r_level;
        end
    endgenerate

    // Delayed copy of the stable levels for rising-edge (press) detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    assign w_rise = w_stable & ~r_stable_d;

    // Lowest-index press wins; any additional simultaneous press is a drop.
    always_comb begin
        w_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_code = 2'(i);
            end
        end
        w_push  = |w_rise;
        w_multi = |(w_rise & (w_rise - 4'd1));
    end

    assign hit     = (mem_addr == BTN_ADDR);
    assign w_pop   = mem_ren & hit & (r_count != '0);
    assign w_flush = mem_wen & hit & mem_wdata[0];
    assign w_full  = (r_count == c_FULL);
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Event FIFO; a flush overrides any push or pop in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else if (w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + (c_AW + 1)'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - (c_AW + 1)'(1);
            end
            if (w_drop || w_multi) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Present the FIFO head as a valid-tagged colour word, zero when empty.
    always_comb begin
        data_out = '0;
        if (r_count != '0) begin
            data_out = {29'd0, r_mem[r_rd_ptr], 1'b1};
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;
    assign pressed  = w_stable;

endmodule
`default_nettype wire

// File: tb/tb_button_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_reader
//  Description : Self-checking bench for button_reader with DEBOUNCE_CYCLES=4
//                and DEPTH=4. Reads push their expected word into a queue;
//                a monitor pops and compares on every processor read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_reader;

    localparam int          c_DC   = 4;
    localparam int          c_DEP  = 4;
    localparam logic [11:0] c_ADDR = 12'd7;

    logic        clock;
    logic        reset;
    logic [3:0]  btn;
    logic [11:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic        hit;
    logic [31:0] data_out;
    logic [2:0]  count;
    logic        overflow;
    logic [3:0]  pressed;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    button_reader #(
        .DEBOUNCE_CYCLES (c_DC),
        .DEPTH           (c_DEP),
        .BTN_ADDR        (c_ADDR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn       (btn),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .hit       (hit),
        .data_out  (data_out),
        .count     (count),
        .overflow  (overflow),
        .pressed   (pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every processor read is compared at the falling edge.
    always @(negedge clock) begin
        if (reset && mem_ren && hit) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_unexpected: got %0h, expected no read", data_out);
            end else begin
                check("read_data", data_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] exp);
        mem_addr = c_ADDR;
        mem_ren  = 1'b1;
        exp_q.push_back(exp);
        tick(1);
        mem_ren  = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_wen   = 1'b1;
        tick(1);
        mem_wen   = 1'b0;
        mem_addr  = c_ADDR;
    endtask

    task automatic press(input int idx);
        btn = 4'b0001 << idx;
        tick(8);
        btn = 4'b0000;
        tick(8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        btn       = 4'b0000;
        mem_addr  = 12'd0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = 32'd0;
        #1;
        check("reset_count",    32'(count),    32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_pressed",  32'(pressed),  32'd0);
        check("reset_data",     data_out,      32'd0);
        tick(2);
        reset = 1'b1;

        // Single red press latency.
        btn = 4'b0001;
        tick(5);
        check("lat_pressed_e5", 32'(pressed), 32'd0);
        tick(1);
        check("lat_pressed_e6", 32'(pressed), 32'd1);
        check("lat_count_e6",   32'(count),   32'd0);
        tick(1);
        check("lat_count_e7",   32'(count),   32'd1);
        check("lat_data_e7",    data_out,     32'h1);
        btn = 4'b0000;
        tick(8);
        check("release_pressed", 32'(pressed), 32'd0);
        check("release_count",   32'(count),   32'd1);
        rd(32'h1);
        check("pop_count", 32'(count), 32'd0);

        // Address decode.
        mem_addr = 12'd8;
        #1;
        check("hit_miss", 32'(hit), 32'd0);
        mem_addr = c_ADDR;
        #1;
        check("hit_match", 32'(hit), 32'd1);

        // Short glitch on yellow.
        btn = 4'b1000;
        tick(3);
        btn = 4'b0000;
        tick(10);
        check("glitch_pressed", 32'(pressed), 32'd0);
        check("glitch_count",   32'(count),   32'd0);

        // Fill with blue, green, yellow, red; then push+pop while full.
        press(1);
        press(2);
        press(3);
        press(0);
        check("fill_count",    32'(count),    32'd4);
        check("fill_overflow", 32'(overflow), 32'd0);
        check("fill_head",     data_out,      32'h3);
        btn = 4'b0100;
        tick(6);
        rd(32'h3);
        check("pushpop_count",    32'(count),    32'd4);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        btn = 4'b0000;
        tick(8);
        rd(32'h5);
        rd(32'h7);
        rd(32'h1);
        rd(32'h5);
        check("drain_count", 32'(count), 32'd0);
        rd(32'h0);
        check("empty_pop_count",    32'(count),    32'd0);
        check("empty_pop_overflow", 32'(overflow), 32'd0);
        check("empty_pop_data",     data_out,      32'h0);
        press(0);
        check("wrap_count", 32'(count), 32'd1);
        rd(32'h1);

        // Overflow by a fifth press, then store effects.
        press(0);
        press(1);
        press(2);
        press(3);
        press(0);
        check("ovf_count",    32'(count),    32'd4);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_head",     data_out,      32'h1);
        wr(c_ADDR, 32'h0);
        check("store0_count",    32'(count),    32'd4);
        check("store0_overflow", 32'(overflow), 32'd1);
        wr(12'd8, 32'h1);
        check("store_miss_count", 32'(count), 32'd4);
        wr(c_ADDR, 32'h1);
        check("flush_count",    32'(count),    32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_data",     data_out,      32'h0);

        // Blue and green together.
        btn = 4'b0110;
        tick(8);
        check("multi_count",    32'(count),    32'd1);
        check("multi_data",     data_out,      32'h3);
        check("multi_overflow", 32'(overflow), 32'd1);
        check("multi_pressed",  32'(pressed),  32'h6);
        btn = 4'b0000;
        tick(8);
        rd(32'h3);
        wr(c_ADDR, 32'h1);
        check("multi_flush_overflow", 32'(overflow), 32'd0);

        // Flush coinciding with a push discards the event.
        btn = 4'b0001;
        tick(6);
        wr(c_ADDR, 32'h1);
        check("flush_push_count",    32'(count),    32'd0);
        check("flush_push_overflow", 32'(overflow), 32'd0);
        btn = 4'b0000;
        tick(8);
        check("flush_push_later", 32'(count), 32'd0);

        // Reset mid-debounce with a non-empty FIFO.
        press(0);
        press(1);
        check("pre_reset_count", 32'(count), 32'd2);
        btn = 4'b0100;
        tick(3);
        reset = 1'b0;
        #1;
        check("async_count",    32'(count),    32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        check("async_pressed",  32'(pressed),  32'd0);
        check("async_data",     data_out,      32'd0);
        tick(2);
        reset = 1'b1;
        tick(6);
        check("post_reset_pressed", 32'(pressed), 32'h4);
        check("post_reset_count6",  32'(count),   32'd0);
        tick(1);
        check("post_reset_count7",  32'(count),   32'd1);
        check("post_reset_data",    data_out,     32'h5);
        rd(32'h5);
        check("post_reset_drain", 32'(count), 32'd0);
        btn = 4'b0000;
        tick(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
